// File: rtl/miriscv_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// miriscv_run_ctrl_if
//   Per-hart data-memory observation bus feeding the run controller.
//   Each hart contributes one request lane; address and data lanes are packed
//   with hart h occupying bits [32h+31:32h].
//
//   Signals
//     mem_req    NUM_HARTS    per-hart data memory request
//     mem_we     NUM_HARTS    per-hart write enable
//     mem_addr   32*NUM_HARTS per-hart byte address
//     mem_wdata  32*NUM_HARTS per-hart write data
//
//   Modports
//     master  driven by the cores (or a testbench standing in for them)
//     slave   observed by miriscv_run_ctrl
// ---------------------------------------------------------------------------
interface miriscv_run_ctrl_if #(
  parameter int unsigned NUM_HARTS = 1
) ();

  logic [NUM_HARTS-1:0]    mem_req;
  logic [NUM_HARTS-1:0]    mem_we;
  logic [32*NUM_HARTS-1:0] mem_addr;
  logic [32*NUM_HARTS-1:0] mem_wdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    input mem_req,
    input mem_we,
    input mem_addr,
    input mem_wdata
  );

endinterface

// File: rtl/miriscv_run_ctrl.sv
// ---------------------------------------------------------------------------
// miriscv_run_ctrl
//   Run controller for miriscv_top regressions. Sequences the reset of one or
//   more cores, watches each hart for its store to the tohost word, enforces
//   a cycle watchdog and reports pass/fail together with an exit code.
//
//   Parameters
//     NUM_HARTS       number of monitored cores (>=1)
//     RST_CYCLES      core reset pulse length in cycles (>=1)
//     TIMEOUT_CYCLES  watchdog limit in RUN cycles; 0 disables the watchdog
//     TOHOST_ADDR     byte address of the tohost word
//     CNT_W           width of the RUN cycle counter
//
//   Ports
//     clk_i        clock, all logic on the rising edge
//     rst_i        synchronous reset, active-high
//     start_i      launch a run (honoured in IDLE and DONE only)
//     mem          per-hart memory observation bus (slave modport)
//     core_rst_o   active-high reset to each core (drives ~rst_n_i of hart h)
//     running_o    controller is in RUN
//     done_o       controller is in DONE
//     pass_o       run passed, valid with done_o
//     timeout_o    watchdog expired, valid with done_o
//     hart_done_o  hart h has written tohost during this run
//     exit_code_o  result code, valid with done_o
//     cycle_cnt_o  RUN cycles elapsed (saturating)
//
//   Build option
//     MIRISCV_RUN_CTRL_SIM_FINISH_EN  when defined, prints a one-line result
//     on the cycle done_o rises and calls $finish one cycle later (simulation
//     only). When undefined the block is fully synthesizable and DONE is held
//     until start_i or rst_i.
// ---------------------------------------------------------------------------
module miriscv_run_ctrl #(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  miriscv_run_ctrl_if.slave       mem,
  output logic [NUM_HARTS-1:0]    core_rst_o,
  output logic                    running_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o,
  output logic [NUM_HARTS-1:0]    hart_done_o,
  output logic [31:0]             exit_code_o,
  output logic [CNT_W-1:0]        cycle_cnt_o
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int unsigned     RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic            WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]     CODE_PASS = 32'h1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                      state_q;
  state_e                      state_d;
  logic [RC_W-1:0]             rst_cnt_q;
  logic [CNT_W-1:0]            cycle_cnt_q;
  logic [NUM_HARTS-1:0]        hart_done_q;
  logic [NUM_HARTS-1:0][31:0]  code_q;
  logic                        pass_q;
  logic                        timeout_q;
  logic [31:0]                 exit_code_q;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic [NUM_HARTS-1:0]        hit;
  logic [NUM_HARTS-1:0][31:0]  code_nxt;
  logic                        all_done;
  logic                        expire;
  logic                        enter_reset;
  logic [CNT_W-1:0]            cnt_inc;
  logic                        pass_nxt;
  logic [31:0]                 exit_nxt;

  // A tohost hit is a write to TOHOST_ADDR from a hart that has not yet
  // reported this run; only the first one per hart is captured.
  always_comb begin
    hit      = '0;
    code_nxt = code_q;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      hit[h] = (state_q == ST_RUN) && mem.mem_req[h] && mem.mem_we[h] &&
               (mem.mem_addr[32*h +: 32] == TOHOST_ADDR) && !hart_done_q[h];
      if (hit[h]) begin
        code_nxt[h] = mem.mem_wdata[32*h +: 32];
      end
    end
  end

  // Completion counts hits landing this cycle, so the final store moves the
  // FSM to DONE on the same edge that records it. Completion beats expiry.
  assign all_done = &(hart_done_q | hit);
  assign expire   = WDOG_EN && (cycle_cnt_q == TO_LAST) && !all_done;

  assign cnt_inc  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

  // Verdict computed from the codes as they will be after this edge. The
  // loop walks from the highest hart down so the lowest failing hart wins.
  always_comb begin
    pass_nxt = !expire;
    exit_nxt = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      if (code_nxt[NUM_HARTS-1-i] != CODE_PASS) begin
        pass_nxt = 1'b0;
        exit_nxt = code_nxt[NUM_HARTS-1-i];
      end
    end
    if (expire) begin
      exit_nxt = '1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i)                state_d = ST_RESET;
      ST_RESET: if (rst_cnt_q == RC_LAST)   state_d = ST_RUN;
      ST_RUN:   if (all_done || expire)     state_d = ST_DONE;
      ST_DONE:  if (start_i)                state_d = ST_RESET;
      default:                              state_d = ST_IDLE;
    endcase
  end

  assign enter_reset = (state_q != ST_RESET) && (state_d == ST_RESET);

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      hart_done_q <= '0;
      code_q      <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
    end else if (enter_reset) begin
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      hart_done_q <= '0;
      code_q      <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
    end else begin
      if ((state_q == ST_RESET) && (rst_cnt_q != RC_LAST)) begin
        rst_cnt_q <= rst_cnt_q + RC_W'(1);
      end
      if (state_q == ST_RUN) begin
        cycle_cnt_q <= cnt_inc;
        hart_done_q <= hart_done_q | hit;
        code_q      <= code_nxt;
        if (state_d == ST_DONE) begin
          pass_q      <= pass_nxt;
          timeout_q   <= expire;
          exit_code_q <= exit_nxt;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign core_rst_o  = {NUM_HARTS{state_q != ST_RUN}};
  assign running_o   = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign hart_done_o = hart_done_q;
  assign exit_code_o = exit_code_q;
  assign cycle_cnt_o = cycle_cnt_q;

  // -------------------------------------------------------------------------
  // Optional simulation end-of-run report
  // -------------------------------------------------------------------------
`ifdef MIRISCV_RUN_CTRL_SIM_FINISH_EN
  logic done_seen_q;
  logic finish_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_seen_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      done_seen_q <= done_o;
      finish_q    <= done_o && !done_seen_q;
      if (done_o && !done_seen_q) begin
        $display("RUN_CTRL: %s code=%h cycles=%0d",
                 timeout_q ? "TIMEOUT" : (pass_q ? "PASS" : "FAIL"),
                 exit_code_q, cycle_cnt_q);
      end
      if (finish_q) begin
        $finish;
      end
    end
  end
`else
  // Synthesizable build: DONE is held until start_i or rst_i.
`endif

endmodule

// File: tb/tb_miriscv_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_miriscv_run_ctrl
//   Self-checking bench for miriscv_run_ctrl with two harts. Each run is
//   described by a per-hart, per-RUN-cycle store table; expected results are
//   derived from the first tohost store per hart (finish = latest first hit,
//   bounded by the watchdog) and compared with the DUT at the end of the run
//   and cycle by cycle while it runs.
// ---------------------------------------------------------------------------
module tb_miriscv_run_ctrl;

  localparam int unsigned NH   = 2;
  localparam int unsigned RSTC = 2;
  localparam int unsigned TMO  = 200;
  localparam logic [31:0] TH   = 32'h0000_1000;
  localparam int unsigned MAXC = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NH-1:0]   core_rst;
  logic            running;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [NH-1:0]   hart_done;
  logic [31:0]     exit_code;
  logic [31:0]     cycle_cnt;

  miriscv_run_ctrl_if #(.NUM_HARTS(NH)) bus ();

  miriscv_run_ctrl #(
    .NUM_HARTS      (NH),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TMO),
    .TOHOST_ADDR    (TH),
    .CNT_W          (32)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mem         (bus),
    .core_rst_o  (core_rst),
    .running_o   (running),
    .done_o      (done),
    .pass_o      (pass),
    .timeout_o   (timeout),
    .hart_done_o (hart_done),
    .exit_code_o (exit_code),
    .cycle_cnt_o (cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Store table: entry [h][c] is what hart h presents during RUN cycle c.
  logic        st_req   [NH][MAXC];
  logic        st_we    [NH][MAXC];
  logic [31:0] st_addr  [NH][MAXC];
  logic [31:0] st_wdata [NH][MAXC];

  task automatic clear_stim();
    for (int h = 0; h < NH; h++) begin
      for (int c = 0; c < MAXC; c++) begin
        st_req[h][c]   = 1'b0;
        st_we[h][c]    = 1'b0;
        st_addr[h][c]  = '0;
        st_wdata[h][c] = '0;
      end
    end
  endtask

  task automatic put(input int h, input int c, input logic we,
                     input logic [31:0] addr, input logic [31:0] data);
    st_req[h][c]   = 1'b1;
    st_we[h][c]    = we;
    st_addr[h][c]  = addr;
    st_wdata[h][c] = data;
  endtask

  task automatic rand_stim();
    for (int h = 0; h < NH; h++) begin
      for (int c = 0; c < MAXC; c++) begin
        st_req[h][c]   = ($urandom % 4) == 0;
        st_we[h][c]    = ($urandom % 2) == 0;
        st_addr[h][c]  = (($urandom % 8) == 0) ? TH :
                         ((($urandom % 2) == 0) ? (TH ^ 32'h4) : $urandom);
        st_wdata[h][c] = (($urandom % 3) == 0) ? 32'($urandom_range(0, 15)) : 32'h1;
      end
    end
  endtask

  task automatic idle_bus();
    bus.mem_req   = '0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
  endtask

  task automatic drive_cycle(input int c);
    for (int h = 0; h < NH; h++) begin
      bus.mem_req[h]          = st_req[h][c];
      bus.mem_we[h]           = st_we[h][c];
      bus.mem_addr[32*h +: 32]  = st_addr[h][c];
      bus.mem_wdata[32*h +: 32] = st_wdata[h][c];
    end
  endtask

  task automatic run_scenario(input string tag, input logic poke_start);
    int          first [NH];
    logic [31:0] code  [NH];
    int          fin;
    int          stop;
    int          c;
    logic        exp_to;
    logic        exp_pass;
    logic [31:0] exp_exit;
    logic [NH-1:0] exp_hd;
    logic [NH-1:0] hd_now;

    // Reference: first tohost write of each hart decides its code.
    fin = 0;
    for (int h = 0; h < NH; h++) begin
      first[h] = MAXC;
      code[h]  = '0;
      for (int k = 0; k < MAXC; k++) begin
        if (first[h] == MAXC && st_req[h][k] && st_we[h][k] && st_addr[h][k] == TH) begin
          first[h] = k;
          code[h]  = st_wdata[h][k];
        end
      end
      if (first[h] > fin) fin = first[h];
    end
    exp_to = (fin > int'(TMO) - 1);
    stop   = exp_to ? int'(TMO) - 1 : fin;
    exp_hd = '0;
    for (int h = 0; h < NH; h++) exp_hd[h] = (first[h] <= stop);
    exp_pass = !exp_to;
    exp_exit = '0;
    if (exp_to) begin
      exp_exit = 32'hFFFF_FFFF;
    end else begin
      for (int h = NH - 1; h >= 0; h--) begin
        if (code[h] != 32'h1) begin
          exp_pass = 1'b0;
          exp_exit = code[h];
        end
      end
    end

    // Launch.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":clr_done"},  done,      0);
    check({tag, ":clr_pass"},  pass,      0);
    check({tag, ":clr_to"},    timeout,   0);
    check({tag, ":clr_exit"},  exit_code, 0);
    check({tag, ":clr_hd"},    hart_done, 0);
    check({tag, ":clr_cnt"},   cycle_cnt, 0);
    for (int k = 0; k < int'(RSTC); k++) begin
      check({tag, ":rst_core"}, core_rst, {NH{1'b1}});
      check({tag, ":rst_run"},  running,  0);
      @(negedge clk);
    end

    // Run.
    c = 0;
    while (!done && c < int'(MAXC)) begin
      hd_now = '0;
      for (int h = 0; h < NH; h++) hd_now[h] = (first[h] < c);
      check({tag, ":run"},      running,   1);
      check({tag, ":run_core"}, core_rst,  0);
      check({tag, ":run_cnt"},  cycle_cnt, 64'(c));
      check({tag, ":run_hd"},   hart_done, hd_now);
      drive_cycle(c);
      if (poke_start) start = ($urandom % 16) == 0;
      @(negedge clk);
      c++;
    end
    idle_bus();
    start = 1'b0;

    check({tag, ":done"},     done,      1);
    check({tag, ":len"},      64'(c),    64'(stop + 1));
    check({tag, ":cnt"},      cycle_cnt, 64'(stop + 1));
    check({tag, ":timeout"},  timeout,   exp_to);
    check({tag, ":pass"},     pass,      exp_pass);
    check({tag, ":exit"},     exit_code, exp_exit);
    check({tag, ":hd"},       hart_done, exp_hd);
    check({tag, ":dn_core"},  core_rst,  {NH{1'b1}});
    check({tag, ":dn_run"},   running,   0);
    repeat (2) @(negedge clk);
    check({tag, ":hold"},     done,      1);
    check({tag, ":hold_cnt"}, cycle_cnt, 64'(stop + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_watchdog: got no end of test, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    idle_bus();
    clear_stim();
    repeat (2) @(negedge clk);
    check("rst_core", core_rst,  {NH{1'b1}});
    check("rst_done", done,      0);
    check("rst_cnt",  cycle_cnt, 0);
    check("rst_run",  running,   0);
    check("rst_pass", pass,      0);
    check("rst_to",   timeout,   0);
    check("rst_exit", exit_code, 0);
    check("rst_hd",   hart_done, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_run",  running,  0);
      check("idle_done", done,     0);
      check("idle_core", core_rst, {NH{1'b1}});
    end

    // Pass, final store at RUN cycle 50.
    clear_stim();
    put(1, 5, 1'b1, TH, 32'h1);
    put(0, 50, 1'b1, TH, 32'h1);
    run_scenario("pass50", 1'b0);

    // Fail code, later store ignored; reads and other addresses ignored.
    clear_stim();
    put(0, 3, 1'b0, TH, 32'h9);
    put(0, 4, 1'b1, TH + 32'h4, 32'h8);
    put(0, 10, 1'b1, TH, 32'h7);
    put(0, 20, 1'b1, TH, 32'h1);
    put(1, 12, 1'b1, TH, 32'h1);
    run_scenario("fail7", 1'b0);

    // Watchdog expiry.
    clear_stim();
    run_scenario("timeout", 1'b0);

    // Completion on the expiry cycle wins.
    clear_stim();
    put(1, 100, 1'b1, TH, 32'h1);
    put(0, 199, 1'b1, TH, 32'h1);
    run_scenario("at199", 1'b0);

    // Two harts, staggered.
    clear_stim();
    put(0, 10, 1'b1, TH, 32'h1);
    put(1, 30, 1'b1, TH, 32'h5);
    run_scenario("two_hart", 1'b0);

    // Same-cycle completion on the first RUN cycle.
    clear_stim();
    put(0, 0, 1'b1, TH, 32'h1);
    put(1, 0, 1'b1, TH, 32'h1);
    run_scenario("same_cyc", 1'b0);

    // Lowest failing hart supplies the code.
    clear_stim();
    put(1, 4, 1'b1, TH, 32'h3);
    put(0, 8, 1'b1, TH, 32'h9);
    run_scenario("lowest", 1'b0);

    // Abort mid-run.
    clear_stim();
    put(0, 5, 1'b1, TH, 32'h1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RSTC) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      drive_cycle(c);
      @(negedge clk);
    end
    idle_bus();
    check("abort_pre_hd", hart_done, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check("abort_core", core_rst,  {NH{1'b1}});
    check("abort_run",  running,   0);
    check("abort_done", done,      0);
    check("abort_cnt",  cycle_cnt, 0);
    check("abort_hd",   hart_done, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle_done", done,    0);
      check("abort_idle_run",  running, 0);
    end

    // Randomized runs, with stray start pulses while running.
    for (int i = 0; i < 24; i++) begin
      rand_stim();
      run_scenario($sformatf("rnd%0d", i), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
